// File: rtl/zoom_mul_pkg.sv
// Shared widths, result-entry type and round-robin helpers for the ZOOM multiplier arbiter.
package zoom_mul_pkg;

    localparam int MUL_A_W      = 5;
    localparam int MUL_B_W      = 4;
    localparam int MUL_C_W      = 9;
    localparam int RR_MAX       = 8;
    localparam int RSP_ID_MAX_W = 3;

    typedef struct packed {
        logic [RSP_ID_MAX_W-1:0] id;
        logic [MUL_C_W-1:0]      c;
    } rsp_entry_t;

    function automatic int rr_next(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return nxt;
    endfunction

    // Lowest valid index at or after ptr, wrapping modulo n; -1 when nothing is valid.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
        int pick;
        int j;
        pick = -1;
        for (int k = 0; k < RR_MAX; k++) begin
            j = ptr + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && (pick < 0) && valid[3'(j)]) begin
                pick = j;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul5x4.sv
// Pipelined 5x4 unsigned multiplier; the product of the inputs appears on c LAT cycles later.
module mul5x4
    import zoom_mul_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic [MUL_A_W-1:0] a,
    input  logic [MUL_B_W-1:0] b,
    output logic [MUL_C_W-1:0] c
);

    logic [LAT-1:0][MUL_C_W-1:0] pipe_q;
    logic [LAT-1:0][MUL_C_W-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = MUL_C_W'(a) * MUL_C_W'(b);
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // No reset: the arbiter's tag valids decide whether a product is meaningful.
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    assign c = pipe_q[LAT-1];

endmodule

// File: rtl/zoom_mul_rsp_fifo.sv
// First-word-fall-through result FIFO; the head is presented while non-empty, zero otherwise.
module zoom_mul_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // A pop frees the slot in the same cycle, so a write into a full FIFO is legal alongside a read.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = bump(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/zoom_mul_arbiter.sv
// Round-robin sharing of one mul5x4 among N_REQ requesters, with credit-limited issue
// and in-order tagged results through a FWFT FIFO.
module zoom_mul_arbiter
    import zoom_mul_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*MUL_A_W-1:0]   req_a,
    input  logic [N_REQ*MUL_B_W-1:0]   req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [MUL_C_W-1:0]         rsp_c,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]               ptr_q, ptr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

    logic [RR_MAX-1:0]             valid_ext;
    int                            grant;
    logic [ID_W-1:0]               grant_id;
    logic                          issue_ok;
    logic                          issue;
    logic [MUL_A_W-1:0]            mul_a;
    logic [MUL_B_W-1:0]            mul_b;
    logic [MUL_C_W-1:0]            mul_c;

    rsp_entry_t                    wr_entry;
    rsp_entry_t                    rd_entry;
    logic                          fifo_wr;
    logic                          fifo_pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [CNT_W-1:0]              fifo_count;

    // Credits come from the registered count only, keeping rsp_ready out of the req_ready cone.
    always_comb begin
        valid_ext               = '0;
        valid_ext[N_REQ-1:0]    = req_valid;
        grant                   = rr_pick(valid_ext, int'(ptr_q), N_REQ);
        grant_id                = ID_W'(grant);
        issue_ok                = (cnt_q < CNT_W'(FIFO_DEPTH));
        req_ready               = '0;
        if ((grant >= 0) && issue_ok && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
        issue = |(req_valid & req_ready);
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        ptr_d = ptr_q;
        if (issue) begin
            mul_a = req_a[int'(grant_id)*MUL_A_W +: MUL_A_W];
            mul_b = req_b[int'(grant_id)*MUL_B_W +: MUL_B_W];
            ptr_d = ID_W'(rr_next(int'(grant_id), N_REQ));
        end
    end

    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant_id;
        for (int i = 1; i < MUL_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign fifo_pop = rsp_valid & rsp_ready;

    always_comb begin
        case ({issue, fifo_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    mul5x4 #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .c   (mul_c)
    );

    // The last tag stage lines up with the multiplier output, so it is the FIFO write strobe.
    always_comb begin
        wr_entry                = '0;
        wr_entry.id[ID_W-1:0]   = tag_id_q[MUL_LAT-1];
        wr_entry.c              = mul_c;
        fifo_wr                 = tag_vld_q[MUL_LAT-1];
    end

    zoom_mul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (rsp_ready),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_id    = rd_entry.id[ID_W-1:0];
    assign rsp_c     = rd_entry.c;
    assign busy      = (cnt_q != '0);

    logic fifo_status_unused;
    assign fifo_status_unused = ^{fifo_count, fifo_full};

    if (ID_W < RSP_ID_MAX_W) begin : g_id_pad
        logic id_pad_unused;
        assign id_pad_unused = |rd_entry.id[RSP_ID_MAX_W-1:ID_W];
    end

endmodule
